ssd_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/ssd_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment
//   display. A double-buffered BCD value is shown one digit per slot. Each slot
//   opens with a blank gap (all anodes off) to stop ghosting. Optional
//   leading-zero blanking is applied. New values are swapped in only at frame
//   boundaries.
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   en           1 = scanning, 0 = display dark
//   load         1-cycle strobe capturing value into the pending buffer
//   value        BCD digits, [3:0] = digit 0 (rightmost)
//   q            code for the segment decoder, 4'hF = blank
//   an           active-low anode selects, an[i] = digit i
//   frame_start  1-cycle pulse on the first cycle of slot 0
//   pending      a loaded value is waiting for the next frame
module ssd_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZB          = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  output logic [3:0]              q,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic                    frame_edge;
  logic [4*N_DIGITS-1:0]   shadow, shadow_nxt, pend_buf;
  logic [N_DIGITS-1:0]     blank, an_nxt;
  logic [3:0]              q_nxt;
  logic                    zero_above;

  // Outputs are registered, so everything is computed for the position the
  // scan will occupy after this edge (cnt_nxt/idx_nxt) rather than the current one.
  always_comb begin
    cnt_nxt    = '0;
    idx_nxt    = '0;
    frame_edge = 1'b0;
    if (state == IDLE) begin
      frame_edge = en;
    end else begin
      if (cnt == CNT_LAST) begin
        idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
        idx_nxt = idx;
      end
      frame_edge = en && (cnt == CNT_LAST) && (idx == IDX_LAST);
    end

    shadow_nxt = shadow;
    if (frame_edge) begin
      if (load)
        shadow_nxt = value;
      else if (pending)
        shadow_nxt = pend_buf;
    end

    // A digit above 0 is blanked when it and every higher digit are zero.
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (shadow_nxt[4*i +: 4] == 4'h0);
      blank[i]   = (LZB != 0) && zero_above;
    end

    q_nxt = blank[idx_nxt] ? 4'hF : shadow_nxt[4*idx_nxt +: 4];

    an_nxt = '1;
    if (cnt_nxt >= BLANK_END)
      an_nxt[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      pend_buf    <= '0;
      pending     <= 1'b0;
      q           <= 4'hF;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        pend_buf <= value;
        pending  <= 1'b1;
      end else if (frame_edge) begin
        pending  <= 1'b0;
      end

      shadow <= shadow_nxt;

      if (!en) begin
        state       <= IDLE;
        cnt         <= '0;
        idx         <= '0;
        q           <= 4'hF;
        an          <= '1;
        frame_start <= 1'b0;
      end else begin
        state       <= SCAN;
        cnt         <= cnt_nxt;
        idx         <= idx_nxt;
        an          <= an_nxt;
        frame_start <= frame_edge;
        if (cnt_nxt == '0)
          q <= q_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl
//   Directed bench for ssd_scan_ctrl (4 digits, 8-cycle slots, 2-cycle gap).
//   A second instance built without leading-zero blanking runs on the same
//   stimulus. Expected per-slot codes are queued when values are loaded and
//   consumed as each slot is observed.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] value;
  logic [3:0]  q, q_raw;
  logic [3:0]  an, an_raw;
  logic        frame_start, fs_raw, pending, pend_raw;

  typedef struct packed {
    logic [3:0] lzb;
    logic [3:0] raw;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic pend_exp = 1'b0;

  ssd_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .q(q), .an(an), .frame_start(frame_start), .pending(pending)
  );

  ssd_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB(0)) dut_nolzb (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .q(q_raw), .an(an_raw), .frame_start(fs_raw), .pending(pend_raw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected codes for one frame: digits above the most significant
  // non-zero digit are blank; digit 0 always shows.
  task automatic push_frame(input logic [15:0] v);
    int   msd = 0;
    exp_t e;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] != 4'h0) msd = i;
    for (int i = 0; i < 4; i++) begin
      e.raw = v[4*i +: 4];
      e.lzb = (i > msd) ? 4'hF : v[4*i +: 4];
      exp_q.push_back(e);
    end
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"}, an, 4'hF);
    chk({tag, "_q"}, q, 4'hF);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_pending"}, pending, pend_exp);
    chk({tag, "_an_nolzb"}, an_raw, 4'hF);
    chk({tag, "_q_nolzb"}, q_raw, 4'hF);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (frame_start === 1'b1) break;
    end
    chk("frame_start_wait", frame_start, 1'b1);
    pend_exp = 1'b0;
  endtask

  // Observes n cycles starting at the first cycle of a frame, optionally
  // pulsing load at cycle ld_a and/or ld_b.
  task automatic run_frame(input int n, input int ld_a, input logic [15:0] va,
                           input int ld_b, input logic [15:0] vb);
    exp_t e = '{lzb: 4'hF, raw: 4'hF};
    for (int k = 0; k < n; k++) begin
      int s = k / 8;
      int c = k % 8;
      logic [3:0] sel;
      logic [3:0] an_e;
      if (c == 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
        end else begin
          e = exp_q.pop_front();
        end
      end
      sel  = 4'b0001 << s;
      an_e = (c < 2) ? 4'hF : ~sel;
      chk("an", an, an_e);
      chk("q", q, e.lzb);
      chk("frame_start", frame_start, k == 0);
      chk("pending", pending, pend_exp);
      chk("an_nolzb", an_raw, an_e);
      chk("q_nolzb", q_raw, e.raw);
      load = 1'b0;
      if (k == ld_a) begin
        load = 1'b1; value = va;
      end else if (k == ld_b) begin
        load = 1'b1; value = vb;
      end
      if (load) pend_exp = 1'b1;
      else if (k == 31) pend_exp = 1'b0;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0;

    // Reset held for three cycles with the scan disabled.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark("reset");
    end
    rst = 1'b0;

    // Load while idle, then start scanning.
    load = 1'b1; value = 16'h1234;
    tick();
    load = 1'b0;
    pend_exp = 1'b1;
    chk("pending_idle", pending, 1'b1);
    en = 1'b1;
    wait_frame();
    push_frame(16'h1234);
    run_frame(32, -1, '0, -1, '0);

    // Load at frame start: current frame unchanged, next frame shows it.
    push_frame(16'h1234);
    run_frame(32, 0, 16'h0040, -1, '0);
    push_frame(16'h0040);
    run_frame(32, 0, 16'h0000, -1, '0);
    push_frame(16'h0000);

    // Two mid-frame loads: last one wins at the next frame.
    run_frame(32, 10, 16'h1111, 20, 16'h2222);
    push_frame(16'h2222);

    // Load coinciding with the frame-start edge lands in that frame.
    run_frame(32, 31, 16'h0903, -1, '0);
    push_frame(16'h0903);
    run_frame(32, -1, '0, -1, '0);
    push_frame(16'h0903);
    run_frame(32, -1, '0, -1, '0);

    // Drop en in slot 2 at cnt = 5.
    push_frame(16'h0903);
    run_frame(21, -1, '0, -1, '0);
    chk("slot2_an", an, 4'b1011);
    chk("slot2_q", q, 4'h9);
    en = 1'b0;
    tick();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      check_dark("en_low");
      tick();
    end
    en = 1'b1;
    wait_frame();
    push_frame(16'h0903);
    run_frame(32, -1, '0, -1, '0);

    // Reset in slot 3 with a value pending: it is discarded.
    push_frame(16'h0903);
    run_frame(26, 3, 16'h5678, -1, '0);
    chk("pending_before_rst", pending, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend_exp = 1'b0;
    exp_q.delete();
    check_dark("mid_rst");
    wait_frame();
    push_frame(16'h0000);
    run_frame(32, -1, '0, -1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
